calendario_display: RTL and testbench
=====================================

Name: calendario_display

Overview:
Display-side reader for the calendar counter's four BCD date digits (du, dd, mu, md). Snapshots the digits once per scan frame and time-multiplexes them onto a 4-digit common-anode 7-segment display as DD.MM. Adds anti-ghosting blanking, invalid-BCD indication and a frame strobe. Sits between the calendar counter and the board display pins.

Parameters:
PRESCALE, 50000, clk cycles per digit slot (>= 2)
BLANK, 8, cycles at start of each slot with all anodes off (0 <= BLANK < PRESCALE)
SEG_ACTIVE_LOW, 1, 1 = seg/dp driven low to light; 0 = high to light
AN_ACTIVE_LOW, 1, 1 = anode enable driven low; 0 = high

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
du   in  4  day units BCD
dd   in  4  day tens BCD
mu   in  4  month units BCD
md   in  4  month tens BCD
seg  out 7  segments, seg[0]=a ... seg[6]=g
dp   out 1  decimal point
an   out 4  digit enables; an[3]=dd, an[2]=du, an[1]=md, an[0]=mu
frame out 1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Clock/reset: one clock; rst asynchronous, active-low, all flops cleared on assertion without waiting for clk.
- Reset state: prescaler pre=0, slot idx=0, snapshot {dd,du,md,mu}={0,1,0,1} (date 01.01), an all inactive, seg all unlit, dp unlit, frame=0.
- Prescaler: pre counts 0..PRESCALE-1, wraps to 0; wrap cycle = tick.
- Slot: on tick idx increments 0->1->2->3->0 (wrap). idx selects an[idx].
- Snapshot: on a tick that moves idx 3->0, du/dd/mu/md are registered into the snapshot; frame=1 that cycle only. Inputs changing at any other time have no visible effect until the next snapshot. No snapshot during the first frame after reset (reset values shown).
- Outputs registered, one-cycle latency from (pre, idx): in cycle N+1, an[idx] active iff pre(N) >= BLANK, all other anodes inactive; seg = decode(snapshot digit for idx(N)); dp lit iff idx(N)==2 and anode active.
- While anodes blanked, seg and dp also driven unlit.
- Decode (lit segments, active-high before polarity): 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg; 10-15 = g only (dash, invalid BCD).
- Polarity: SEG_ACTIVE_LOW inverts seg/dp; AN_ACTIVE_LOW inverts an. Inactive level follows same rule.
- Reset mid-slot: outputs go inactive immediately; scan restarts from idx=0, pre=0 after release.

Optional Feature:
CALENDARIO_DISPLAY_LZB_EN: leading-zero blanking. Defined: if snapshot dd==0, slot 3 anode stays inactive for the whole slot; if snapshot md==0, slot 1 likewise. Undefined: zeros displayed as '0'. Units digits and dp never blanked by this feature.

Test Plan:
- PRESCALE=4, BLANK=1, active-low: hold rst=0 -> an=4'b1111, seg=7'b1111111, dp=1, frame=0; release -> cycle 2 after release an=4'b1110, seg=7'b1111001 ('1', mu).
- Inputs dd=2,du=3,md=1,mu=1 held: first frame shows 01.01; after first 3->0 tick frame=1 one cycle, next frame an sequence 1110,1101,1011,0111 with digits 1,1,3,2; dp=0 only during an=1011.
- Change du 3->7 mid-frame (idx=1) -> slot 2 still shows 3; 7 appears only after next frame pulse.
- du=4'hA snapshotted -> slot 2 seg=7'b0111111 (dash), dp still lit.
- Assert rst while idx=2, pre=3 -> an/seg/dp inactive same cycle (asynchronous); after release scan restarts at idx=0, snapshot 01.01.
- With CALENDARIO_DISPLAY_LZB_EN, dd=0,md=0 -> an[3] and an[1] never active; without macro both show '0' (seg=7'b1000000).

Source files
------------

// File: rtl/calendario_display.sv
// calendario_display: snapshots the BCD date digits once per scan frame and multiplexes
// them as DD.MM onto a 4-digit 7-segment display. Optional macro: CALENDARIO_DISPLAY_LZB_EN.
module calendario_display #(
    parameter int unsigned PRESCALE       = 50000,
    parameter int unsigned BLANK          = 8,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] du,
    input  logic [3:0] dd,
    input  logic [3:0] mu,
    input  logic [3:0] md,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame
);

    localparam int unsigned   PW       = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [6:0]    SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic [3:0]    AN_OFF   = {4{AN_ACTIVE_LOW}};

    logic [PW-1:0] pre;
    logic [1:0]    idx;
    logic [3:0]    s_du, s_dd, s_mu, s_md;
    logic          tick;
    logic [3:0]    digit;
    logic          lit;
    logic [3:0]    an_hi;
    logic [6:0]    seg_hi;
    logic          dp_hi;

    // Segment pattern, active-high, bit0=a .. bit6=g; non-BCD codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b1000000;
        endcase
    endfunction

    assign tick = (pre == PRE_LAST);

    always_comb begin
        digit = s_mu;
        case (idx)
            2'd0: digit = s_mu;
            2'd1: digit = s_md;
            2'd2: digit = s_du;
            2'd3: digit = s_dd;
            default: digit = s_mu;
        endcase

        lit = (32'(pre) >= BLANK);
`ifdef CALENDARIO_DISPLAY_LZB_EN
        if ((idx == 2'd3) && (s_dd == 4'd0)) lit = 1'b0;
        if ((idx == 2'd1) && (s_md == 4'd0)) lit = 1'b0;
`endif

        an_hi  = lit ? (4'b0001 << idx) : '0;
        seg_hi = lit ? decode(digit) : '0;
        dp_hi  = lit && (idx == 2'd2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre   <= '0;
            idx   <= '0;
            s_dd  <= 4'd0;
            s_du  <= 4'd1;
            s_md  <= 4'd0;
            s_mu  <= 4'd1;
            an    <= AN_OFF;
            seg   <= SEG_OFF;
            dp    <= SEG_ACTIVE_LOW;
            frame <= 1'b0;
        end else begin
            // The snapshot lands together with the frame pulse, as the scan returns to slot 0.
            frame <= tick && (idx == 2'd3);
            if (tick) begin
                pre <= '0;
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    s_dd <= dd;
                    s_du <= du;
                    s_md <= md;
                    s_mu <= mu;
                end
            end else begin
                pre <= pre + 1'b1;
            end
            an  <= an_hi ^ AN_OFF;
            seg <= seg_hi ^ SEG_OFF;
            dp  <= dp_hi ^ SEG_ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_calendario_display.sv
// Directed bench for calendario_display with PRESCALE=4, BLANK=1, active-low seg and anodes.
module tb_calendario_display;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] du = 4'd0, dd = 4'd0, mu = 4'd0, md = 4'd0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame;

    int checks = 0;
    int errors = 0;
    int k = 0;

    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always #5 clk = ~clk;

    calendario_display #(
        .PRESCALE(4),
        .BLANK(1),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .du(du),
        .dd(dd),
        .mu(mu),
        .md(md),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame(frame)
    );

    // Hand-written active-low patterns, seg[0]=a .. seg[6]=g.
    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        case (d)
            4'd0:    exp_seg = 7'b1000000;
            4'd1:    exp_seg = 7'b1111001;
            4'd2:    exp_seg = 7'b0100100;
            4'd3:    exp_seg = 7'b0110000;
            4'd4:    exp_seg = 7'b0011001;
            4'd5:    exp_seg = 7'b0010010;
            4'd6:    exp_seg = 7'b0000010;
            4'd7:    exp_seg = 7'b1111000;
            4'd8:    exp_seg = 7'b0000000;
            4'd9:    exp_seg = 7'b0010000;
            default: exp_seg = 7'b0111111;
        endcase
    endfunction

    // k counts sampling points: at k the outputs after the k-th posedge since release are visible.
    task automatic do_reset;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        k = 0;
    endtask

    task automatic advance_to(input int target);
        while (k < target) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset;
        du = 4'd3; dd = 4'd2; mu = 4'd1; md = 4'd1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b expected %b", an, 4'b1111); end
        checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg: got %b expected %b", seg, 7'b1111111); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b expected %b", dp, 1'b1); end
        checks++; if (frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b expected %b", frame, 1'b0); end
        rst = 1'b1;
        k = 0;
        advance_to(1);
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL release_blank_an: got %b expected %b", an, 4'b1111); end
        advance_to(2);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL release_an: got %b expected %b", an, 4'b1110); end
        checks++; if (seg !== 7'b1111001) begin errors++; $display("FAIL release_seg: got %b expected %b", seg, 7'b1111001); end
    endtask

    task automatic test_first_frames;
        logic [3:0] first_dig [4];
        logic [3:0] next_dig [4];
        first_dig = '{4'd1, 4'd0, 4'd1, 4'd0};
        next_dig  = '{4'd1, 4'd1, 4'd3, 4'd2};
        du = 4'd3; dd = 4'd2; mu = 4'd1; md = 4'd1;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            advance_to(2 + 4 * s);
            checks++; if (an !== an_tab[s]) begin errors++; $display("FAIL frame0_an slot%0d: got %b expected %b", s, an, an_tab[s]); end
            checks++; if (seg !== exp_seg(first_dig[s])) begin errors++; $display("FAIL frame0_seg slot%0d: got %b expected %b", s, seg, exp_seg(first_dig[s])); end
        end
        advance_to(15);
        checks++; if (frame !== 1'b0) begin errors++; $display("FAIL frame_early: got %b expected %b", frame, 1'b0); end
        advance_to(16);
        checks++; if (frame !== 1'b1) begin errors++; $display("FAIL frame_pulse: got %b expected %b", frame, 1'b1); end
        advance_to(17);
        checks++; if (frame !== 1'b0) begin errors++; $display("FAIL frame_one_cycle: got %b expected %b", frame, 1'b0); end
        for (int s = 0; s < 4; s++) begin
            advance_to(17 + 4 * s);
            checks++; if (an !== 4'b1111) begin errors++; $display("FAIL blank_an slot%0d: got %b expected %b", s, an, 4'b1111); end
            checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL blank_seg slot%0d: got %b expected %b", s, seg, 7'b1111111); end
            advance_to(18 + 4 * s);
            checks++; if (an !== an_tab[s]) begin errors++; $display("FAIL frame1_an slot%0d: got %b expected %b", s, an, an_tab[s]); end
            checks++; if (seg !== exp_seg(next_dig[s])) begin errors++; $display("FAIL frame1_seg slot%0d: got %b expected %b", s, seg, exp_seg(next_dig[s])); end
            checks++; if (dp !== ((s == 2) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL frame1_dp slot%0d: got %b expected %b", s, dp, (s == 2) ? 1'b0 : 1'b1); end
        end
    endtask

    task automatic test_midframe_change;
        du = 4'd3; dd = 4'd2; mu = 4'd1; md = 4'd1;
        do_reset();
        advance_to(21);
        du = 4'd7;
        advance_to(26);
        checks++; if (seg !== exp_seg(4'd3)) begin errors++; $display("FAIL midframe_hold_seg: got %b expected %b", seg, exp_seg(4'd3)); end
        checks++; if (an !== 4'b1011) begin errors++; $display("FAIL midframe_hold_an: got %b expected %b", an, 4'b1011); end
        advance_to(32);
        checks++; if (frame !== 1'b1) begin errors++; $display("FAIL midframe_frame2: got %b expected %b", frame, 1'b1); end
        advance_to(42);
        checks++; if (seg !== exp_seg(4'd7)) begin errors++; $display("FAIL midframe_new_seg: got %b expected %b", seg, exp_seg(4'd7)); end
    endtask

    task automatic test_invalid_bcd;
        du = 4'hA; dd = 4'd2; mu = 4'd1; md = 4'd1;
        do_reset();
        advance_to(26);
        checks++; if (an !== 4'b1011) begin errors++; $display("FAIL invalid_an: got %b expected %b", an, 4'b1011); end
        checks++; if (seg !== 7'b0111111) begin errors++; $display("FAIL invalid_seg: got %b expected %b", seg, 7'b0111111); end
        checks++; if (dp !== 1'b0) begin errors++; $display("FAIL invalid_dp: got %b expected %b", dp, 1'b0); end
    endtask

    task automatic test_async_reset;
        du = 4'd3; dd = 4'd2; mu = 4'd5; md = 4'd1;
        do_reset();
        advance_to(27);
        checks++; if (an !== 4'b1011) begin errors++; $display("FAIL async_pre_an: got %b expected %b", an, 4'b1011); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL async_an: got %b expected %b", an, 4'b1111); end
        checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL async_seg: got %b expected %b", seg, 7'b1111111); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL async_dp: got %b expected %b", dp, 1'b1); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        k = 0;
        advance_to(1);
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL async_restart_blank: got %b expected %b", an, 4'b1111); end
        advance_to(2);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL async_restart_an: got %b expected %b", an, 4'b1110); end
        checks++; if (seg !== exp_seg(4'd1)) begin errors++; $display("FAIL async_restart_seg: got %b expected %b", seg, exp_seg(4'd1)); end
        advance_to(6);
        checks++; if (seg !== exp_seg(4'd0)) begin errors++; $display("FAIL async_restart_md: got %b expected %b", seg, exp_seg(4'd0)); end
    endtask

    task automatic test_zero_digits;
        du = 4'd3; dd = 4'd0; mu = 4'd4; md = 4'd0;
        do_reset();
        advance_to(18);
        checks++; if (seg !== exp_seg(4'd4)) begin errors++; $display("FAIL zero_mu_seg: got %b expected %b", seg, exp_seg(4'd4)); end
        advance_to(22);
`ifdef CALENDARIO_DISPLAY_LZB_EN
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL lzb_md_an: got %b expected %b", an, 4'b1111); end
        checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL lzb_md_seg: got %b expected %b", seg, 7'b1111111); end
`else
        checks++; if (an !== 4'b1101) begin errors++; $display("FAIL zero_md_an: got %b expected %b", an, 4'b1101); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL zero_md_seg: got %b expected %b", seg, 7'b1000000); end
`endif
        advance_to(26);
        checks++; if (seg !== exp_seg(4'd3)) begin errors++; $display("FAIL zero_du_seg: got %b expected %b", seg, exp_seg(4'd3)); end
        checks++; if (dp !== 1'b0) begin errors++; $display("FAIL zero_du_dp: got %b expected %b", dp, 1'b0); end
        advance_to(30);
`ifdef CALENDARIO_DISPLAY_LZB_EN
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL lzb_dd_an: got %b expected %b", an, 4'b1111); end
        checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL lzb_dd_seg: got %b expected %b", seg, 7'b1111111); end
`else
        checks++; if (an !== 4'b0111) begin errors++; $display("FAIL zero_dd_an: got %b expected %b", an, 4'b0111); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL zero_dd_seg: got %b expected %b", seg, 7'b1000000); end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_frames();
        test_midframe_change();
        test_invalid_bcd();
        test_async_reset();
        test_zero_digits();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
